seq_det_param: RTL and testbench



---
 rtl/seq_det_param.sv | 83 ++++++++
 tb/tb_seq_det_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector with run-time overlap mode and saturating match counter.
// Optional macro SEQ_DET_MOORE_OUT_EN registers OP (one-cycle pulse after the match); default OP is combinational.
module seq_det_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8,
  localparam int                FILL_W  = $clog2(SEQ_LEN)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In,
  input  logic              En,
  input  logic              Ovl,
  input  logic              Clr,
  output logic              OP,
  output logic [FILL_W-1:0] Fill,
  output logic [CNT_W-1:0]  Count
);

  localparam logic [FILL_W-1:0] FILL_ARMED = FILL_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEQ_LEN-1:0] window;
  logic               match;

  // The candidate window is the stored history followed by the bit arriving now.
  assign window = {hist_q, In};
  assign match  = En && (fill_q == FILL_ARMED) && (window == PATTERN);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (En) begin
      hist_d = window[SEQ_LEN-2:0];
      // Non-overlapping mode restarts collection so the next match needs a full fresh pattern.
      if (match && !Ovl) begin
        fill_d = '0;
      end else if (fill_q != FILL_ARMED) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    if (Clr) begin
      count_d = '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

`ifdef SEQ_DET_MOORE_OUT_EN
  logic op_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      op_q <= 1'b0;
    end else begin
      op_q <= match;
    end
  end

  assign OP = op_q;
`else
  assign OP = match;
`endif

  assign Fill  = fill_q;
  assign Count = count_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: directed bit streams push hand-computed expectations,
// a monitor pops and compares OP, Fill and Count every checked cycle.
module tb_seq_det_param;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic In  = 1'b0;
  logic En  = 1'b0;
  logic Ovl = 1'b0;
  logic Clr = 1'b0;
  int   sel = 0;
  logic chkValid = 1'b0;
  logic prevMatch = 1'b0;

  int checks = 0;
  int errors = 0;
  int stepNo = 0;

  typedef struct {
    int   step;
    logic op;
    int   fill;
    int   count;
  } expRec_t;

  expRec_t expQ[$];

  logic       enA, enB, enC;
  logic       opA, opB, opC;
  logic [1:0] fillA, fillB;
  logic [2:0] fillC;
  logic [7:0] countA, countC;
  logic [1:0] countB;
  logic       obsOp;
  int         obsFill, obsCount;

  always #5 Clk = ~Clk;

  assign enA = En && (sel == 0);
  assign enB = En && (sel == 1);
  assign enC = En && (sel == 2);

  seq_det_param dutA (
    .Clk(Clk), .Rst(Rst), .In(In), .En(enA), .Ovl(Ovl), .Clr(Clr),
    .OP(opA), .Fill(fillA), .Count(countA)
  );

  seq_det_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) dutB (
    .Clk(Clk), .Rst(Rst), .In(In), .En(enB), .Ovl(Ovl), .Clr(Clr),
    .OP(opB), .Fill(fillB), .Count(countB)
  );

  seq_det_param #(.SEQ_LEN(5), .PATTERN(5'b11011), .CNT_W(8)) dutC (
    .Clk(Clk), .Rst(Rst), .In(In), .En(enC), .Ovl(Ovl), .Clr(Clr),
    .OP(opC), .Fill(fillC), .Count(countC)
  );

  always_comb begin
    obsOp    = opA;
    obsFill  = int'(fillA);
    obsCount = int'(countA);
    case (sel)
      1: begin
        obsOp    = opB;
        obsFill  = int'(fillB);
        obsCount = int'(countB);
      end
      2: begin
        obsOp    = opC;
        obsFill  = int'(fillC);
        obsCount = int'(countC);
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // OP is sampled mid-cycle (before the edge consuming the bit); Fill/Count just after that edge.
  initial begin
    logic    opSeen;
    expRec_t e;
    forever begin
      @(negedge Clk);
      if (chkValid) begin
        opSeen = obsOp;
        @(posedge Clk);
        #1;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard: output presented with no expectation queued");
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("step%0d op", e.step), int'(opSeen), int'(e.op));
          checkOutput($sformatf("step%0d fill", e.step), obsFill, e.fill);
          checkOutput($sformatf("step%0d count", e.step), obsCount, e.count);
        end
      end
    end
  end

  // expMatch is the combinational match of this cycle; the registered variant lags by one cycle.
  task automatic applyStimulus(input logic bitIn, input logic bitEn, input logic mode,
                               input logic clear, input logic expMatch,
                               input int expFill, input int expCount);
    expRec_t r;
    @(posedge Clk);
    #2;
    In       = bitIn;
    En       = bitEn;
    Ovl      = mode;
    Clr      = clear;
    chkValid = 1'b1;
    stepNo++;
    r.step  = stepNo;
`ifdef SEQ_DET_MOORE_OUT_EN
    r.op    = prevMatch;
`else
    r.op    = expMatch;
`endif
    r.fill  = expFill;
    r.count = expCount;
    expQ.push_back(r);
    prevMatch = expMatch;
  endtask

  task automatic idle();
    @(posedge Clk);
    #2;
    En        = 1'b0;
    Clr       = 1'b0;
    chkValid  = 1'b0;
    prevMatch = 1'b0;
  endtask

  task automatic applyReset(input int which);
    @(posedge Clk);
    #2;
    chkValid  = 1'b0;
    En        = 1'b0;
    Clr       = 1'b0;
    sel       = which;
    Rst       = 1'b0;
    #20;
    Rst       = 1'b1;
    prevMatch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Test 1: non-overlapping 1010 detection.
    applyReset(0);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 2, 0);
    applyStimulus(1, 1, 0, 0, 0, 3, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 2, 1);
    applyStimulus(1, 1, 0, 0, 0, 3, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    idle();

    // Test 5: asynchronous reset mid-pattern, Count starts at 2 from test 1.
    applyStimulus(1, 1, 0, 0, 0, 1, 2);
    applyStimulus(0, 1, 0, 0, 0, 2, 2);
    applyStimulus(1, 1, 0, 0, 0, 3, 2);
    @(posedge Clk);
    #2;
    chkValid = 1'b0;
    In       = 1'b0;
    En       = 1'b1;
    #1;
`ifdef SEQ_DET_MOORE_OUT_EN
    checkOutput("t5 op before reset", int'(obsOp), 0);
`else
    checkOutput("t5 op before reset", int'(obsOp), 1);
`endif
    Rst = 1'b0;
    #1;
    checkOutput("t5 op in reset", int'(obsOp), 0);
    checkOutput("t5 fill in reset", obsFill, 0);
    checkOutput("t5 count in reset", obsCount, 0);
    En = 1'b0;
    @(negedge Clk);
    Rst       = 1'b1;
    prevMatch = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 2, 0);
    applyStimulus(0, 1, 0, 0, 0, 3, 0);
    applyStimulus(1, 1, 0, 0, 0, 3, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle();

    // Test 2: overlapping 1010 detection.
    applyReset(0);
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 2, 0);
    applyStimulus(1, 1, 1, 0, 0, 3, 0);
    applyStimulus(0, 1, 1, 0, 1, 3, 1);
    applyStimulus(1, 1, 1, 0, 0, 3, 1);
    applyStimulus(0, 1, 1, 0, 1, 3, 2);
    applyStimulus(1, 1, 1, 0, 0, 3, 2);
    applyStimulus(0, 1, 1, 0, 1, 3, 3);
    applyStimulus(0, 0, 1, 0, 0, 3, 3);
    idle();

    // Test 3: enable gaps are invisible to detection.
    applyReset(0);
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 2, 0);
    applyStimulus(1, 1, 1, 0, 0, 3, 0);
    applyStimulus(1, 0, 1, 0, 0, 3, 0);
    applyStimulus(0, 0, 1, 0, 0, 3, 0);
    applyStimulus(1, 0, 1, 0, 0, 3, 0);
    applyStimulus(0, 1, 1, 0, 1, 3, 1);
    applyStimulus(0, 0, 1, 0, 0, 3, 1);
    idle();

    // Test 4: 2-bit counter saturates, Clr wins over a simultaneous match.
    applyReset(1);
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 2, 0);
    applyStimulus(1, 1, 1, 0, 0, 3, 0);
    applyStimulus(0, 1, 1, 0, 1, 3, 1);
    applyStimulus(1, 1, 1, 0, 0, 3, 1);
    applyStimulus(0, 1, 1, 0, 1, 3, 2);
    applyStimulus(1, 1, 1, 0, 0, 3, 2);
    applyStimulus(0, 1, 1, 0, 1, 3, 3);
    applyStimulus(1, 1, 1, 0, 0, 3, 3);
    applyStimulus(0, 1, 1, 0, 1, 3, 3);
    applyStimulus(1, 1, 1, 0, 0, 3, 3);
    applyStimulus(0, 1, 1, 1, 1, 3, 0);
    applyStimulus(0, 0, 1, 0, 0, 3, 0);
    idle();

    // Test 6: 5-bit pattern 11011 with overlap.
    applyReset(2);
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 2, 0);
    applyStimulus(0, 1, 1, 0, 0, 3, 0);
    applyStimulus(1, 1, 1, 0, 0, 4, 0);
    applyStimulus(1, 1, 1, 0, 1, 4, 1);
    applyStimulus(0, 1, 1, 0, 0, 4, 1);
    applyStimulus(1, 1, 1, 0, 0, 4, 1);
    applyStimulus(1, 1, 1, 0, 1, 4, 2);
    applyStimulus(0, 0, 1, 0, 0, 4, 2);
    idle();

    repeat (3) @(posedge Clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
